// File: rtl/memory_access_unit.sv
// Load/store front end for a word-wide data RAM with a combinational read port.
// Takes one byte-addressed request at a time over a valid/ready handshake,
// performs byte/halfword stores as read-modify-write, sign/zero-extends loads,
// and reports misaligned, illegal-size and out-of-range accesses as faults.
//
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   requestValid/requestReady         request handshake (ready only in IDLE)
//   requestWrite/Size/Signed/Address/Data   request fields, latched at acceptance
//   responseValid/Data/Fault          one-cycle completion pulse and result
//   ramAddress/ramDataC/ramWriteEnable      RAM address, write data and strobe
//   ramDataIn                         RAM read data for ramAddress
module memory_access_unit #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DEPTH     = 281,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 requestValid,
  output logic                 requestReady,
  input  logic                 requestWrite,
  input  logic [1:0]           requestSize,
  input  logic                 requestSigned,
  input  logic [ADDR_BITS+1:0] requestAddress,
  input  logic [DATA_BITS-1:0] requestData,
  output logic                 responseValid,
  output logic [DATA_BITS-1:0] responseData,
  output logic                 responseFault,
  output logic [ADDR_BITS-1:0] ramAddress,
  output logic [DATA_BITS-1:0] ramDataC,
  output logic                 ramWriteEnable,
  input  logic [DATA_BITS-1:0] ramDataIn
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;

  state_t state_q, state_d;

  logic                 write_q;
  logic [1:0]           size_q;
  logic                 signed_q;
  logic [ADDR_BITS-1:0] word_q;
  logic [1:0]           off_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 fault_q;
  logic [DATA_BITS-1:0] merge_q;

  logic [ADDR_BITS-1:0] req_word;
  logic [1:0]           req_off;
  logic                 req_fault;
  logic                 accept;

  logic [7:0]           lane_b;
  logic [15:0]          lane_h;
  logic [DATA_BITS-1:0] merged;
  logic [DATA_BITS-1:0] load_data;

  // Request decode and fault classification on the live inputs
  assign req_word  = requestAddress[ADDR_BITS+1:2];
  assign req_off   = requestAddress[1:0];
  assign req_fault = (requestSize == SIZE_BAD)
                   || ((requestSize == SIZE_HALF) && req_off[0])
                   || ((requestSize == SIZE_WORD) && (req_off != 2'b00))
                   || (32'(req_word) >= DEPTH);
  assign accept    = (state_q == IDLE) && requestValid;

  // Request latches and read-word capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      word_q   <= '0;
      off_q    <= 2'b00;
      data_q   <= '0;
      fault_q  <= 1'b0;
      merge_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q  <= requestWrite;
        size_q   <= requestSize;
        signed_q <= requestSigned;
        word_q   <= req_word;
        off_q    <= req_off;
        data_q   <= requestData;
        fault_q  <= req_fault;
      end
      if (state_q == READ) merge_q <= ramDataIn;
    end
  end

  // Little-endian lane merge for stores and lane extraction for loads
  always_comb begin
    lane_b    = merge_q[{off_q, 3'b000} +: 8];
    lane_h    = merge_q[{off_q[1], 4'b0000} +: 16];
    merged    = merge_q;
    load_data = merge_q;
    case (size_q)
      SIZE_BYTE: begin
        merged[{off_q, 3'b000} +: 8] = data_q[7:0];
        load_data = {{(DATA_BITS-8){signed_q & lane_b[7]}}, lane_b};
      end
      SIZE_HALF: begin
        merged[{off_q[1], 4'b0000} +: 16] = data_q[15:0];
        load_data = {{(DATA_BITS-16){signed_q & lane_h[15]}}, lane_h};
      end
      default: ;
    endcase
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d        = state_q;
    requestReady   = 1'b0;
    responseValid  = 1'b0;
    responseFault  = 1'b0;
    responseData   = '0;
    ramAddress     = '0;
    ramDataC       = '0;
    ramWriteEnable = 1'b0;
    case (state_q)
      IDLE: begin
        requestReady = !reset;
        if (requestValid) begin
          if (req_fault)                                      state_d = RESPOND;
          else if (requestWrite && (requestSize == SIZE_WORD)) state_d = WRITE;
          else                                                state_d = READ;
        end
      end
      READ: begin
        ramAddress = word_q;
        state_d    = write_q ? WRITE : RESPOND;
      end
      WRITE: begin
        ramWriteEnable = 1'b1;
        ramAddress     = word_q;
        ramDataC       = (size_q == SIZE_WORD) ? data_q : merged;
        state_d        = RESPOND;
      end
      RESPOND: begin
        responseValid = 1'b1;
        responseFault = fault_q;
        if (!fault_q && !write_q) responseData = load_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: bench-side RAM, behavioural reference model,
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_memory_access_unit;

  localparam int unsigned ADDR_BITS = 10;
  localparam int unsigned DEPTH     = 281;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned PRELOAD   = 301;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        requestValid = 1'b0;
  logic        requestWrite = 1'b0;
  logic [1:0]  requestSize = 2'b00;
  logic        requestSigned = 1'b0;
  logic [11:0] requestAddress = '0;
  logic [31:0] requestData = '0;
  logic        requestReady;
  logic        responseValid;
  logic [31:0] responseData;
  logic        responseFault;
  logic [9:0]  ramAddress;
  logic [31:0] ramDataC;
  logic        ramWriteEnable;
  logic [31:0] ramDataIn;

  always #5 clock = ~clock;

  memory_access_unit #(.ADDR_BITS(ADDR_BITS), .DEPTH(DEPTH), .DATA_BITS(DATA_BITS)) dut (
    .clock(clock), .reset(reset),
    .requestValid(requestValid), .requestReady(requestReady),
    .requestWrite(requestWrite), .requestSize(requestSize),
    .requestSigned(requestSigned), .requestAddress(requestAddress),
    .requestData(requestData),
    .responseValid(responseValid), .responseData(responseData),
    .responseFault(responseFault),
    .ramAddress(ramAddress), .ramDataC(ramDataC),
    .ramWriteEnable(ramWriteEnable), .ramDataIn(ramDataIn)
  );

  // Bench RAM with combinational read and a preload port
  logic [31:0] mem [0:1023];
  int          write_count = 0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clock) begin
    if (ramWriteEnable) begin
      mem[ramAddress] <= ramDataC;
      write_count     <= write_count + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end
  assign ramDataIn = mem[ramAddress];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, one outstanding transaction, cycle timeline
  logic [31:0] ref_mem [0:1023];
  int          cyc = 0;
  int          idle_from = 0;
  int          acc_cyc = 0;
  int          prev_acc = 0;
  int          exp_writes = 0;
  int          m_lat = 0;
  bit          pending = 0;
  bit          wr_pending = 0;
  bit          m_write = 0;
  bit          m_fault = 0;
  logic [9:0]  m_word = '0;
  logic [31:0] m_new = '0;
  logic [31:0] m_resp = '0;

  initial begin
    bit          accept;
    logic [9:0]  word;
    logic [1:0]  off;
    logic [31:0] old, shifted, mask, lane;
    int          sh;
    forever begin
      @(posedge clock or posedge reset);
      if (clock && pre_we) ref_mem[pre_addr] = pre_data;
      if (reset) begin
        pending    = 0;
        wr_pending = 0;
      end else if (clock) begin
        accept = requestValid && !(pending && cyc < idle_from);
        cyc++;
        if (wr_pending && cyc == acc_cyc + m_lat - 1) begin
          ref_mem[m_word] = m_new;
          exp_writes++;
          wr_pending = 0;
        end
        if (accept) begin
          word    = requestAddress[11:2];
          off     = requestAddress[1:0];
          sh      = 8 * int'(off);
          m_fault = (requestSize == 2'b11) || (requestSize == 2'b01 && off[0])
                 || (requestSize == 2'b10 && off != 2'b00) || (int'(word) >= int'(DEPTH));
          m_write = requestWrite;
          m_word  = word;
          old     = ref_mem[word];
          shifted = old >> sh;
          m_resp  = 32'h0;
          m_new   = 32'h0;
          if (m_fault)                           m_lat = 1;
          else if (!requestWrite)                m_lat = 2;
          else if (requestSize == 2'b10)         m_lat = 2;
          else                                   m_lat = 3;
          if (!m_fault && !requestWrite) begin
            if (requestSize == 2'b00) begin
              lane = shifted & 32'hFF;
              if (requestSigned && lane[7]) lane = lane | 32'hFFFF_FF00;
              m_resp = lane;
            end else if (requestSize == 2'b01) begin
              lane = shifted & 32'hFFFF;
              if (requestSigned && lane[15]) lane = lane | 32'hFFFF_0000;
              m_resp = lane;
            end else begin
              m_resp = old;
            end
          end
          if (!m_fault && requestWrite) begin
            if (requestSize == 2'b10) m_new = requestData;
            else begin
              mask  = ((requestSize == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
              m_new = (old & ~mask) | ((requestData << sh) & mask);
            end
          end
          prev_acc   = acc_cyc;
          acc_cyc    = cyc;
          idle_from  = cyc + m_lat;
          pending    = 1;
          wr_pending = requestWrite && !m_fault;
        end
      end
    end
  end

  // Per-cycle compare against the model
  logic [31:0] last_data = '0;
  bit          last_fault = 0;
  int          last_k = 0;

  initial begin
    bit busy;
    int k, ph;
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        chk("rst_ready",  32'(requestReady), 32'h0);
        chk("rst_rvalid", 32'(responseValid), 32'h0);
        chk("rst_rfault", 32'(responseFault), 32'h0);
        chk("rst_rdata",  responseData, 32'h0);
        chk("rst_raddr",  32'(ramAddress), 32'h0);
        chk("rst_wdata",  ramDataC, 32'h0);
        chk("rst_we",     32'(ramWriteEnable), 32'h0);
      end else begin
        busy = pending && (cyc < idle_from);
        k    = cyc - acc_cyc + 1;
        if (!busy)                                    ph = 0;
        else if (k == m_lat)                          ph = 3;
        else if (m_write && !m_fault && k == m_lat-1) ph = 2;
        else                                          ph = 1;
        chk("ready",  32'(requestReady), 32'(!busy));
        chk("rvalid", 32'(responseValid), 32'(ph == 3));
        chk("we",     32'(ramWriteEnable), 32'(ph == 2));
        case (ph)
          0: begin
            chk("idle_raddr", 32'(ramAddress), 32'h0);
            chk("idle_wdata", ramDataC, 32'h0);
          end
          1: chk("read_raddr", 32'(ramAddress), 32'(m_word));
          2: begin
            chk("write_raddr", 32'(ramAddress), 32'(m_word));
            chk("write_wdata", ramDataC, m_new);
          end
          default: begin
            chk("resp_fault", 32'(responseFault), 32'(m_fault));
            chk("resp_data",  responseData, m_resp);
            last_data  = responseData;
            last_fault = responseFault;
            last_k     = k;
          end
        endcase
      end
    end
  end

  task automatic preload_one(input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_we = 1'b0;
  endtask

  task automatic scramble();
    requestWrite   = 1'($urandom);
    requestSize    = 2'($urandom);
    requestSigned  = 1'($urandom);
    requestAddress = 12'($urandom);
    requestData    = $urandom;
  endtask

  // Present a request at the current negedge and return at the negedge after acceptance
  task automatic issue(input bit w, input logic [1:0] sz, input bit sg,
                       input logic [11:0] ad, input logic [31:0] d, input bit hold);
    int n = 0;
    requestValid = 1'b1; requestWrite = w; requestSize = sz;
    requestSigned = sg; requestAddress = ad; requestData = d;
    while (!requestReady && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: ready stayed 0 for %0d cycles", n);
    end
    @(posedge clock);
    @(negedge clock);
    if (!hold) begin
      requestValid = 1'b0;
      scramble();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (pending && cyc < idle_from && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL response_timeout: no completion within %0d cycles", n);
    end
  endtask

  initial begin
    int wc0, mism;
    int wsel, w;
    logic [1:0] sz;
    // preload under reset
    for (int i = 0; i < int'(PRELOAD); i++) begin
      @(negedge clock);
      pre_we = 1'b1; pre_addr = 10'(i);
      pre_data = (i == 5) ? 32'h1122_3344 : (i == 7) ? 32'hCAFE_F00D : $urandom;
    end
    @(negedge clock);
    pre_we = 1'b0;
    reset  = 1'b0;
    @(negedge clock);

    // byte store then byte loads
    wc0 = write_count;
    issue(1, 2'b00, 0, 12'h015, 32'h0000_00AB, 0); wait_done();
    chk("bst_fault",  32'(last_fault), 32'h0);
    chk("bst_lat",    32'(last_k), 32'd3);
    chk("bst_writes", 32'(write_count - wc0), 32'd1);
    chk("bst_ram",    mem[5], 32'h1122_AB44);
    issue(0, 2'b00, 1, 12'h015, 32'h0, 0); wait_done();
    chk("bld_s_data", last_data, 32'hFFFF_FFAB);
    chk("bld_s_lat",  32'(last_k), 32'd2);
    issue(0, 2'b00, 0, 12'h015, 32'h0, 0); wait_done();
    chk("bld_u_data", last_data, 32'h0000_00AB);

    // halfword store and signed load on a fresh word
    preload_one(10'd5, 32'h1122_3344);
    issue(1, 2'b01, 0, 12'h016, 32'h0000_8001, 0); wait_done();
    chk("hst_ram", mem[5], 32'h8001_3344);
    issue(0, 2'b01, 1, 12'h016, 32'h0, 0); wait_done();
    chk("hld_data", last_data, 32'hFFFF_8001);

    // faults
    issue(0, 2'b01, 0, 12'h013, 32'h0, 0); wait_done();
    chk("f_mis_fault", 32'(last_fault), 32'h1);
    chk("f_mis_lat",   32'(last_k), 32'd1);
    chk("f_mis_data",  last_data, 32'h0);
    wc0 = write_count;
    issue(1, 2'b10, 0, 12'h464, 32'hDEAD_BEEF, 0); wait_done();
    chk("f_oor_fault",  32'(last_fault), 32'h1);
    chk("f_oor_writes", 32'(write_count - wc0), 32'd0);
    issue(0, 2'b11, 0, 12'h020, 32'h0, 0); wait_done();
    chk("f_size_fault", 32'(last_fault), 32'h1);

    // held valid with two queued requests
    issue(0, 2'b10, 0, 12'h014, 32'h0, 1);
    issue(0, 2'b00, 0, 12'h015, 32'h0, 0); wait_done();
    chk("hs_gap",  32'(acc_cyc - prev_acc), 32'd3);
    chk("hs_data", last_data, 32'h0000_0033);

    // reset during READ of a byte store
    wc0 = write_count;
    issue(1, 2'b00, 0, 12'h01C, 32'h0000_0055, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #3;
    chk("rst_ready_after", 32'(requestReady), 32'h1);
    repeat (3) @(negedge clock);
    chk("rst_ram",    mem[7], 32'hCAFE_F00D);
    chk("rst_writes", 32'(write_count - wc0), 32'd0);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      wsel = int'($urandom_range(0, 9));
      sz   = (wsel < 3) ? 2'b00 : (wsel < 6) ? 2'b01 : (wsel < 9) ? 2'b10 : 2'b11;
      w    = ($urandom_range(0, 15) == 0) ? int'($urandom_range(278, 300))
                                          : int'($urandom_range(0, 20));
      issue(1'($urandom), sz, 1'($urandom), {10'(w), 2'($urandom)}, $urandom,
            ($urandom_range(0, 3) == 0));
      if (requestValid) issue(1'($urandom), 2'($urandom), 1'($urandom),
                              {10'($urandom_range(0, 20)), 2'($urandom)}, $urandom, 0);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    mism = 0;
    for (int i = 0; i < int'(PRELOAD); i++) if (mem[i] !== ref_mem[i]) mism++;
    chk("ram_image_mismatches", 32'(mism), 32'h0);
    chk("write_count", 32'(write_count), 32'(exp_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
